down_timer: RTL and testbench

- Loadable down-counting timer; the counterpart to the team's free-running up counter (count toward zero instead of away from it).
- Loads a start value, decrements once per clock, and reports terminal count with a one-cycle `done` pulse.
- Supports pause, abort and optional auto-reload for periodic ticks.
- Sits beside the up counter in timing/sequencing logic; one timer per delay or period to generate.

---
 rtl/down_timer.sv | 117 +++++++++++
 tb/tb_down_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with pause, abort and optional
// auto-reload. Emits a registered one-cycle done pulse at terminal count.
module down_timer #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             done_r;
  logic             done_s;
  logic             busy_r;
  logic             busy_s;

  // Next-state logic: stop > start > pause > decrement; done defaults low.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    reload_s = reload_r;
    done_s   = 1'b0;
    if (stop) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
    end else if (start) begin
      reload_s = load_val;
      cnt_s    = load_val;
      if (load_val == CNT_ZERO) begin
        // Zero-length timer: finish immediately without ever going busy.
        state_s = ST_IDLE;
        done_s  = 1'b1;
      end else begin
        state_s = ST_RUN;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (pause) begin
            state_s = ST_PAUSED;
          end else if (cnt_r > CNT_ONE) begin
            cnt_s = cnt_r - CNT_ONE;
          end else begin
            // Terminal count: cnt_r is 1 here, so zero is never decremented.
            done_s = 1'b1;
            if (AUTO_RELOAD) begin
              cnt_s   = reload_r;
              state_s = ST_RUN;
            end else begin
              cnt_s   = CNT_ZERO;
              state_s = ST_IDLE;
            end
          end
        end
        ST_PAUSED: begin
          // Leaving pause costs one cycle with the count held.
          if (pause) begin
            state_s = ST_PAUSED;
          end else begin
            state_s = ST_RUN;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      reload_r <= reload_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
    end
  end

  assign cnt  = cnt_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: one-shot and auto-reload instances
// share stimulus; a behavioural model is compared every cycle, plus
// hand-computed literal checks at key points.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] load_val = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] cnt0, cnt1;
  logic       busy0, busy1, done0, done1;

  int n_vec = 0;
  int n_err = 0;

  // model: index 0 = one-shot, index 1 = auto-reload
  int m_cnt[2];
  int m_rel[2];
  bit m_busy[2];
  bit m_frozen[2];
  bit m_done[2];

  down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .stop(stop),
    .pause(pause), .cnt(cnt0), .busy(busy0), .done(done0)
  );

  down_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_val(load_val), .start(start), .stop(stop),
    .pause(pause), .cnt(cnt1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a timer is idle, running or frozen; count moves
  // toward 1, then either stops at 0 or wraps to the reload value.
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_busy[i] = 0; m_frozen[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (stop) begin
          m_busy[i] = 0; m_frozen[i] = 0; m_cnt[i] = 0;
        end else if (start) begin
          m_rel[i] = load_val;
          m_cnt[i] = load_val;
          m_frozen[i] = 0;
          m_busy[i] = (load_val != 0);
          m_done[i] = (load_val == 0);
        end else if (m_busy[i]) begin
          if (m_frozen[i]) m_frozen[i] = pause;
          else if (pause) m_frozen[i] = 1;
          else if (m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
          else begin
            m_done[i] = 1;
            if (i == 1) m_cnt[i] = m_rel[i];
            else begin m_cnt[i] = 0; m_busy[i] = 0; end
          end
        end
      end
    end
  end

  // Compare process: check both instances against the model each cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("cnt0", cnt0, m_cnt[0]);
      chk("busy0", busy0, m_busy[0]);
      chk("done0", done0, m_done[0]);
      chk("cnt1", cnt1, m_cnt[1]);
      chk("busy1", busy1, m_busy[1]);
      chk("done1", done1, m_done[1]);
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic tick(input bit s, input bit sp, input bit p, input int lv);
    start = s; stop = sp; pause = p; load_val = lv[7:0];
    @(negedge clk);
  endtask

  int n;
  int pulses;
  bit zero_seen;

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_busy0", busy0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // one-shot of 3
    tick(1, 0, 0, 3);
    chk("os_cnt3", cnt0, 3);
    chk("os_busy", busy0, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("os_cnt1", cnt0, 1);
    tick(0, 0, 0, 0);
    chk("os_done", done0, 1);
    chk("os_cnt0", cnt0, 0);
    chk("os_idle", busy0, 0);
    tick(0, 0, 0, 0);
    chk("os_done_1cyc", done0, 0);
    tick(0, 1, 0, 0);

    // pause/resume with 5: done 9 cycles after start
    tick(1, 0, 0, 5);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("pz_cnt3", cnt0, 3);
    for (int k = 0; k < 3; k++) tick(0, 0, 1, 0);
    chk("pz_frozen", cnt0, 3);
    chk("pz_busy", busy0, 1);
    tick(0, 0, 0, 0);
    chk("pz_resume", cnt0, 3);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("pz_done_early", done0, 0);
    tick(0, 0, 0, 0);
    chk("pz_done", done0, 1);
    tick(0, 1, 0, 0);

    // restart while running, then stop beats start
    tick(1, 0, 0, 5);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    chk("rs_cnt2", cnt0, 2);
    tick(1, 0, 0, 10);
    chk("rs_cnt10", cnt0, 10);
    chk("rs_nodone", done0, 0);
    tick(1, 1, 0, 7);
    chk("sp_cnt", cnt0, 0);
    chk("sp_busy", busy0, 0);
    chk("sp_done", done0, 0);

    // start with pause high still enters RUN
    tick(1, 0, 1, 2);
    chk("sp_run", cnt0, 2);
    tick(0, 0, 1, 0);
    chk("sp_paused", cnt0, 2);
    tick(0, 1, 0, 0);

    // async reset mid-run at cnt=5
    tick(1, 0, 0, 9);
    for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);
    chk("ar_cnt5", cnt0, 5);
    #2 rst = 1'b0;
    #1;
    chk("ar_cnt0", cnt0, 0);
    chk("ar_busy0", busy0, 0);
    chk("ar_done0", done0, 0);
    chk("ar_cnt1", cnt1, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(0, 0, 0, 0);
    chk("ar_post_cnt", cnt0, 0);
    chk("ar_post_busy", busy0, 0);

    // auto-reload with 4 on dut1
    tick(1, 0, 0, 4);
    chk("rl_cnt4", cnt1, 4);
    pulses = 0;
    zero_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick(0, 0, 0, 7);
      if (done1) pulses++;
      if (cnt1 == 8'd0) zero_seen = 1;
      if (k == 3) chk("rl_wrap", cnt1, 4);
    end
    chk("rl_pulses", pulses, 3);
    chk("rl_nozero", zero_seen, 0);
    tick(0, 1, 0, 0);
    chk("rl_stop_cnt", cnt1, 0);
    chk("rl_stop_busy", busy1, 0);

    // zero-length timer
    tick(1, 0, 0, 0);
    chk("z_done0", done0, 1);
    chk("z_done1", done1, 1);
    chk("z_busy0", busy0, 0);
    tick(0, 0, 0, 0);
    chk("z_done_1cyc", done0, 0);

    // full-range 255
    tick(1, 0, 0, 255);
    n = 0;
    while (!done0 && n < 300) begin
      tick(0, 0, 0, 0);
      n++;
    end
    chk("max_latency", n, 255);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
